rs_entry_rpl: RTL and testbench
===============================

// Module: rs_entry_rpl
//
// PURPOSE
// - One reservation-station slot for the next-generation scheduler. It generalises the
//   single-shot entry to N sources, adds replay after issue, ROB-ordered flush and an
//   age counter for oldest-first select.
// - Sits between dispatch (alloc, rs0) and the RS picker/issue stage (rs1). It tracks
//   physical-source readiness from IPRF write-back wakeups (ro0).
//
// PARAMETERS
// - NUM_SRCS      2  number of tracked physical sources (1..3)
// - REPLAY_WIN    2  cycles after grant during which e_cancel_rs may return the entry
// - AGE_W         4  width of the saturating age counter
//
// PORTS
// - clk              in   1          clock
// - reset            in   1          asynchronous, active-low reset
// - iprf_wr_en_ro0   in   [IPRF_NUM_WRITES]             wakeup write enables
// - iprf_wr_pkt_ro0  in   t_prf_wr_pkt[IPRF_NUM_WRITES] wakeup packets (pdst matched)
// - e_alloc_rs0      in   1          allocate this slot; only legal when ~e_valid
// - q_alloc_static_rs0 in t_rs_entry_static  dispatch payload
// - e_cancel_rs      in   1          issued uop must replay (e.g. load miss)
// - flush_valid      in   1          ROB flush request
// - flush_robid      in   t_rob_id   flush point; entries younger-or-equal are killed
// - e_gnt_issue_rs1  in   1          picker grant; only legal with e_req_issue_rs1
// - e_valid          out  1          slot occupied (VALID or ISSUED)
// - e_static         out  t_rs_entry_static  captured payload
// - e_req_issue_rs1  out  1          VALID, all sources ready, no flush this cycle
// - e_issue_pkt_rs1  out  t_uinstr_iss  issue payload (uinstr, robid, pdst; vals/meta 0)
// - e_age            out  AGE_W      cycles since alloc, saturating
// - e_dealloc        out  1          one-cycle pulse when the slot frees
//
// BEHAVIOUR
// - Reset: fsm=IDLE; e_valid, e_req_issue_rs1 and e_dealloc are 0; e_age=0; src
//   pending bits=1. e_static is not reset (it is don't-care when IDLE).
// - FSM: IDLE -(alloc)-> VALID -(gnt)-> ISSUED.
//   ISSUED: cancel and win_cnt<REPLAY_WIN go to VALID.
//   ISSUED: win_cnt==REPLAY_WIN-1 with no cancel goes to IDLE and pulses e_dealloc.
// - win_cnt clears on grant and increments each ISSUED cycle. A cancel arriving outside
//   ISSUED is ignored.
// - Flush: when flush_valid and the entry robid is younger than or equal to flush_robid
//   (rob_defs wrap-bit compare), the next state is IDLE from any state and e_dealloc
//   pulses. Flush beats grant, cancel and wakeup in the same cycle.
// - Source tracking, per source:
//   - pend is loaded at alloc from rename.psrcN_pend.
//   - pend clears when any iprf_wr_en_ro0[i] is set with iprf_wr_pkt_ro0[i].pdst == psrc.
//   - An alloc-cycle wakeup bypasses, so the source enters already ready.
//   - Unused sources (index >= NUM_SRCS, or descr optype none) allocate ready.
// - Ready timing: ready_rs1 = ~pend registered. The earliest request is one cycle after
//   the last wakeup.
// - Replay keeps sources ready: the entry re-requests on the cycle after the cancel.
// - e_age: cleared at alloc, +1 per cycle while e_valid, saturates at 2^AGE_W-1, and is
//   not reset by a replay.
// - Alloc while e_valid is an assertion error. Grant without request is an assertion
//   error.
//
// STRUCTURE
// - rob_defs package: t_rob_id and rob_younger_eq(a,b) compare function.
// - common package: t_rs_src_trk_static {psrc_pend, psrc, descr}.
// - This file: t_rs_entry_static; t_rs_ent_fsm {IDLE, VALID, ISSUED}.
// - One sub-module, rs_src_trk (one per source via generate). It holds the pend bit and
//   does wakeup compare/bypass; output ready_rs1.
// - Flops use the async-low-reset DFF macro variants.
//
// TESTING
// - Alloc with src1 pend (psrc 5) and src2 ready; wakeup pdst=5 at cycle t -> e_req_issue_rs1=1 at t+1.
// - Alloc with wakeup pdst=5 in the same cycle -> request on the first cycle after alloc.
// - Grant at t; cancel at t+1 -> VALID at t+2 and request re-asserts at t+2.
//   Grant again with no cancel -> e_dealloc at t+REPLAY_WIN.
// - Entry robid 0x12, flush_robid 0x10 at the same time as gnt -> IDLE next cycle,
//   e_dealloc=1, no ISSUED.
//   Entry robid 0x0F -> entry survives.
// - Wrap: entry robid {1,0x02}, flush {0,0x3E} -> killed; AGE_W=4 held 20 cycles -> e_age=15.
// - Drop reset mid-ISSUED -> outputs 0 asynchronously; restart alloc works with no stale pend.

Source files
------------

// File: rtl/rs_entry_rpl_pkg.sv
// Shared types for the replayable reservation-station entry: ROB ids and their
// age compare, wakeup packets, source/entry payloads and the entry FSM encoding.
package rs_entry_rpl_pkg;

  localparam int IPRF_NUM_WRITES = 2;
  localparam int PRF_IDX_W       = 6;
  localparam int ROB_IDX_W       = 6;
  localparam int MAX_SRCS        = 3;
  localparam int DATA_W          = 16;
  localparam int UINSTR_W        = 16;

  typedef logic [PRF_IDX_W-1:0] t_prf_id;

  typedef struct packed {
    logic                 wrap;
    logic [ROB_IDX_W-1:0] idx;
  } t_rob_id;

  typedef struct packed {
    t_prf_id pdst;
  } t_prf_wr_pkt;

  typedef enum logic [0:0] {
    OPT_NONE = 1'b0,
    OPT_REG  = 1'b1
  } t_optype;

  typedef struct packed {
    logic    psrc_pend;
    t_prf_id psrc;
    t_optype descr;
  } t_rs_src_trk_static;

  typedef struct packed {
    logic [UINSTR_W-1:0]                    uinstr;
    t_rob_id                                robid;
    t_prf_id                                pdst;
    t_rs_src_trk_static [MAX_SRCS-1:0]      src;
  } t_rs_entry_static;

  typedef struct packed {
    logic [UINSTR_W-1:0]                    uinstr;
    t_rob_id                                robid;
    t_prf_id                                pdst;
    logic [MAX_SRCS-1:0][DATA_W-1:0]        vals;
    logic [3:0]                             meta;
  } t_uinstr_iss;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    ISSUED = 2'd2
  } t_rs_ent_fsm;

  // a is younger than or equal to b; the wrap bit flips each time the ROB index wraps
  function automatic logic rob_younger_eq(input t_rob_id a, input t_rob_id b);
    logic res_s;
    if (a.wrap == b.wrap) begin
      res_s = (a.idx >= b.idx);
    end else begin
      res_s = (a.idx < b.idx);
    end
    return res_s;
  endfunction

endpackage

// File: rtl/rs_entry_rpl_chk.sv
// Protocol checker for rs_entry_rpl: no allocation into an occupied slot and no
// grant without a request (a grant coinciding with a flush is dropped by the slot).
module rs_entry_rpl_chk (
  input  logic clk,
  input  logic reset,
  input  logic e_alloc_rs0,
  input  logic e_valid,
  input  logic e_gnt_issue_rs1,
  input  logic e_req_issue_rs1,
  input  logic flush_valid
);

  a_alloc_when_idle: assert property (@(posedge clk) disable iff (!reset)
    e_alloc_rs0 |-> !e_valid);

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!reset)
    (e_gnt_issue_rs1 && !flush_valid) |-> e_req_issue_rs1);

endmodule

bind rs_entry_rpl rs_entry_rpl_chk u_chk (
  .clk             (clk),
  .reset           (reset),
  .e_alloc_rs0     (e_alloc_rs0),
  .e_valid         (e_valid),
  .e_gnt_issue_rs1 (e_gnt_issue_rs1),
  .e_req_issue_rs1 (e_req_issue_rs1),
  .flush_valid     (flush_valid)
);

// File: rtl/rs_entry_rpl_src_trk.sv
// Per-source readiness tracker: holds the pending bit, clears it on a matching
// write-back wakeup and bypasses a wakeup that lands in the allocation cycle.
module rs_entry_rpl_src_trk
  import rs_entry_rpl_pkg::*;
#(
  parameter bit SRC_USED = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    alloc_rs0,
  input  logic                                    active,
  input  t_rs_src_trk_static                      alloc_src_rs0,
  input  t_prf_id                                 psrc,
  input  logic [IPRF_NUM_WRITES-1:0]              iprf_wr_en_ro0,
  input  t_prf_wr_pkt [IPRF_NUM_WRITES-1:0]       iprf_wr_pkt_ro0,
  output logic                                    ready_rs1
);

  logic pend_r;
  logic pend_nxt_s;
  logic alloc_hit_s;
  logic trk_hit_s;

  // wakeup compare against both the incoming and the captured source tag
  always_comb begin
    alloc_hit_s = 1'b0;
    trk_hit_s   = 1'b0;
    for (int i = 0; i < IPRF_NUM_WRITES; i++) begin
      alloc_hit_s = alloc_hit_s | (iprf_wr_en_ro0[i] & (iprf_wr_pkt_ro0[i].pdst == alloc_src_rs0.psrc));
      trk_hit_s   = trk_hit_s   | (iprf_wr_en_ro0[i] & (iprf_wr_pkt_ro0[i].pdst == psrc));
    end
    if (alloc_rs0) begin
      pend_nxt_s = SRC_USED & (alloc_src_rs0.descr == OPT_REG) & alloc_src_rs0.psrc_pend & ~alloc_hit_s;
    end else if (active & trk_hit_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // pending bit register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= 1'b1;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign ready_rs1 = ~pend_r;

endmodule

// File: rtl/rs_entry_rpl.sv
// One reservation-station slot with N tracked sources, replay after issue,
// ROB-ordered flush and a saturating age counter for oldest-first select.
module rs_entry_rpl
  import rs_entry_rpl_pkg::*;
#(
  parameter int NUM_SRCS   = 2,
  parameter int REPLAY_WIN = 2,
  parameter int AGE_W      = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [IPRF_NUM_WRITES-1:0]              iprf_wr_en_ro0,
  input  t_prf_wr_pkt [IPRF_NUM_WRITES-1:0]       iprf_wr_pkt_ro0,
  input  logic                                    e_alloc_rs0,
  input  t_rs_entry_static                        q_alloc_static_rs0,
  input  logic                                    e_cancel_rs,
  input  logic                                    flush_valid,
  input  t_rob_id                                 flush_robid,
  input  logic                                    e_gnt_issue_rs1,
  output logic                                    e_valid,
  output t_rs_entry_static                        e_static,
  output logic                                    e_req_issue_rs1,
  output t_uinstr_iss                             e_issue_pkt_rs1,
  output logic [AGE_W-1:0]                        e_age,
  output logic                                    e_dealloc
);

  localparam int WIN_W = $clog2(REPLAY_WIN + 1);

  t_rs_ent_fsm        state_r;
  t_rs_ent_fsm        state_nxt_s;
  logic [WIN_W-1:0]   win_cnt_r;
  logic [AGE_W-1:0]   age_r;
  t_rs_entry_static   e_static_r;
  logic [MAX_SRCS-1:0] src_rdy_s;
  logic               kill_s;
  logic               alloc_take_s;
  logic               active_s;
  logic               win_last_s;
  logic               cancel_ok_s;

  assign active_s     = (state_r != IDLE);
  assign alloc_take_s = e_alloc_rs0 & (state_r == IDLE);
  assign kill_s       = flush_valid & active_s & rob_younger_eq(e_static_r.robid, flush_robid);
  assign win_last_s   = (win_cnt_r == WIN_W'(REPLAY_WIN - 1));
  assign cancel_ok_s  = e_cancel_rs & (win_cnt_r < WIN_W'(REPLAY_WIN));

  for (genvar s = 0; s < MAX_SRCS; s++) begin : g_src
    rs_entry_rpl_src_trk #(
      .SRC_USED ((s < NUM_SRCS) ? 1'b1 : 1'b0)
    ) u_trk (
      .clk             (clk),
      .reset           (reset),
      .alloc_rs0       (alloc_take_s),
      .active          (active_s),
      .alloc_src_rs0   (q_alloc_static_rs0.src[s]),
      .psrc            (e_static_r.src[s].psrc),
      .iprf_wr_en_ro0  (iprf_wr_en_ro0),
      .iprf_wr_pkt_ro0 (iprf_wr_pkt_ro0),
      .ready_rs1       (src_rdy_s[s])
    );
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state: flush wins over grant, cancel and window expiry; a grant racing a flush is dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (e_alloc_rs0) state_nxt_s = VALID;
        else             state_nxt_s = IDLE;
      end
      VALID: begin
        if (kill_s)                               state_nxt_s = IDLE;
        else if (e_gnt_issue_rs1 & ~flush_valid)  state_nxt_s = ISSUED;
        else                                      state_nxt_s = VALID;
      end
      ISSUED: begin
        if (kill_s)           state_nxt_s = IDLE;
        else if (cancel_ok_s) state_nxt_s = VALID;
        else if (win_last_s)  state_nxt_s = IDLE;
        else                  state_nxt_s = ISSUED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    e_valid         = active_s;
    e_req_issue_rs1 = (state_r == VALID) & (&src_rdy_s) & ~flush_valid;
    e_dealloc       = active_s & (state_nxt_s == IDLE);
  end

  // replay window counter, restarted by each accepted grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_r <= {WIN_W{1'b0}};
    end else if ((state_r == VALID) & e_gnt_issue_rs1) begin
      win_cnt_r <= {WIN_W{1'b0}};
    end else if (state_r == ISSUED) begin
      win_cnt_r <= win_cnt_r + WIN_W'(1);
    end else begin
      win_cnt_r <= win_cnt_r;
    end
  end

  // saturating age; replay does not restart it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_r <= {AGE_W{1'b0}};
    end else if (alloc_take_s) begin
      age_r <= {AGE_W{1'b0}};
    end else if (active_s & (age_r != {AGE_W{1'b1}})) begin
      age_r <= age_r + AGE_W'(1);
    end else begin
      age_r <= age_r;
    end
  end

  // payload capture; contents are meaningless while the slot is idle
  always_ff @(posedge clk) begin
    if (alloc_take_s) begin
      e_static_r <= q_alloc_static_rs0;
    end else begin
      e_static_r <= e_static_r;
    end
  end

  // issue packet drawn straight from the captured payload
  always_comb begin
    e_issue_pkt_rs1        = '0;
    e_issue_pkt_rs1.uinstr = e_static_r.uinstr;
    e_issue_pkt_rs1.robid  = e_static_r.robid;
    e_issue_pkt_rs1.pdst   = e_static_r.pdst;
  end

  assign e_static = e_static_r;
  assign e_age    = age_r;

endmodule

// File: tb/tb_rs_entry_rpl.sv
// Self-checking bench for rs_entry_rpl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural slot model.
module tb_rs_entry_rpl;
  import rs_entry_rpl_pkg::*;

  localparam int NUM_SRCS   = 2;
  localparam int REPLAY_WIN = 2;
  localparam int AGE_W      = 4;
  localparam int AGE_MAX    = (1 << AGE_W) - 1;

  logic                              clk = 1'b0;
  logic                              reset;
  logic [IPRF_NUM_WRITES-1:0]        wen;
  t_prf_wr_pkt [IPRF_NUM_WRITES-1:0] wpkt;
  logic                              alloc;
  t_rs_entry_static                  q;
  logic                              cancel;
  logic                              flush;
  t_rob_id                           frob;
  logic                              gnt;
  logic                              e_valid;
  t_rs_entry_static                  e_static;
  logic                              e_req;
  t_uinstr_iss                       e_pkt;
  logic [AGE_W-1:0]                  e_age;
  logic                              e_dealloc;

  always #5 clk = ~clk;

  rs_entry_rpl #(
    .NUM_SRCS   (NUM_SRCS),
    .REPLAY_WIN (REPLAY_WIN),
    .AGE_W      (AGE_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .iprf_wr_en_ro0     (wen),
    .iprf_wr_pkt_ro0    (wpkt),
    .e_alloc_rs0        (alloc),
    .q_alloc_static_rs0 (q),
    .e_cancel_rs        (cancel),
    .flush_valid        (flush),
    .flush_robid        (frob),
    .e_gnt_issue_rs1    (gnt),
    .e_valid            (e_valid),
    .e_static           (e_static),
    .e_req_issue_rs1    (e_req),
    .e_issue_pkt_rs1    (e_pkt),
    .e_age              (e_age),
    .e_dealloc          (e_dealloc)
  );

  int n_chk = 0;
  int n_err = 0;

  // behavioural model of the slot
  bit                  m_occ;
  bit                  m_iss;
  int                  m_since;
  int                  m_age;
  bit [MAX_SRCS-1:0]   m_pend;
  t_rs_entry_static    m_static;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ROB ids live on a 128-entry circle; a is younger-or-equal if it lies within half a lap ahead of b
  function automatic bit yeq(input t_rob_id a, input t_rob_id b);
    logic [6:0] av;
    logic [6:0] bv;
    logic [6:0] d;
    av = a;
    bv = b;
    d  = av - bv;
    return d < 7'd64;
  endfunction

  function automatic bit hit(input t_prf_id p);
    for (int i = 0; i < IPRF_NUM_WRITES; i++) begin
      if (wen[i] && wpkt[i].pdst == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_occ   = 1'b0;
    m_iss   = 1'b0;
    m_since = 0;
    m_age   = 0;
    m_pend  = '1;
  endtask

  function automatic bit model_req();
    return m_occ && !m_iss && (m_pend == '0) && !flush;
  endfunction

  task automatic eval_cycle();
    bit                kill;
    bit                can_ok;
    bit                exp_dl;
    bit [MAX_SRCS-1:0] np;
    t_uinstr_iss       exp_pkt;
    kill   = m_occ && flush && yeq(m_static.robid, frob);
    can_ok = m_occ && m_iss && cancel && (m_since < REPLAY_WIN);
    exp_dl = m_occ && (kill || (m_iss && !can_ok && m_since == REPLAY_WIN - 1));
    chk_eq("valid",   128'(e_valid),   128'(m_occ));
    chk_eq("req",     128'(e_req),     128'(model_req()));
    chk_eq("dealloc", 128'(e_dealloc), 128'(exp_dl));
    chk_eq("age",     128'(e_age),     128'(m_age));
    if (m_occ) begin
      exp_pkt        = '0;
      exp_pkt.uinstr = m_static.uinstr;
      exp_pkt.robid  = m_static.robid;
      exp_pkt.pdst   = m_static.pdst;
      chk_eq("static",  128'(e_static), 128'(m_static));
      chk_eq("iss_pkt", 128'(e_pkt),    128'(exp_pkt));
    end
    np = m_pend;
    if (!m_occ && alloc) begin
      for (int s = 0; s < MAX_SRCS; s++)
        np[s] = (s < NUM_SRCS) && (q.src[s].descr == OPT_REG) && q.src[s].psrc_pend && !hit(q.src[s].psrc);
    end else if (m_occ) begin
      for (int s = 0; s < MAX_SRCS; s++)
        if (hit(m_static.src[s].psrc)) np[s] = 1'b0;
    end
    m_pend = np;
    if (!m_occ && alloc) m_age = 0;
    else if (m_occ && m_age < AGE_MAX) m_age++;
    if (kill) begin
      m_occ = 1'b0;
      m_iss = 1'b0;
    end else if (!m_occ) begin
      if (alloc) begin
        m_occ    = 1'b1;
        m_iss    = 1'b0;
        m_static = q;
      end
    end else if (!m_iss) begin
      if (gnt && !flush) begin
        m_iss   = 1'b1;
        m_since = 0;
      end
    end else if (can_ok) begin
      m_iss = 1'b0;
    end else if (m_since == REPLAY_WIN - 1) begin
      m_occ = 1'b0;
      m_iss = 1'b0;
    end else begin
      m_since++;
    end
  endtask

  task automatic clr();
    alloc  = 1'b0;
    cancel = 1'b0;
    flush  = 1'b0;
    frob   = '0;
    gnt    = 1'b0;
    wen    = '0;
    wpkt   = '0;
  endtask

  // inputs are set at a falling edge; check just after, then advance to the next falling edge
  task automatic tick();
    #1;
    eval_cycle();
    @(negedge clk);
    clr();
  endtask

  task automatic mk_q(input logic [6:0] rid, input bit p0, input logic [5:0] s0,
                      input bit p1, input logic [5:0] s1);
    q.uinstr = 16'($urandom);
    q.robid  = rid;
    q.pdst   = 6'($urandom);
    q.src[0] = '{psrc_pend: p0,   psrc: s0,    descr: OPT_REG};
    q.src[1] = '{psrc_pend: p1,   psrc: s1,    descr: OPT_REG};
    q.src[2] = '{psrc_pend: 1'b1, psrc: 6'd63, descr: OPT_REG};
    alloc    = 1'b1;
  endtask

  task automatic wake(input int slot, input logic [5:0] p);
    wen[slot]       = 1'b1;
    wpkt[slot].pdst = p;
  endtask

  initial begin
    reset = 1'b0;
    q     = '0;
    clr();
    model_reset();
    tick();
    tick();
    reset = 1'b1;

    // wakeup at t -> request at t+1, then grant / cancel / replay / dealloc
    mk_q(7'h05, 1'b1, 6'd5, 1'b0, 6'd9);
    tick();
    tick();
    wake(0, 6'd5);
    tick();
    chk_eq("wake_req", 128'(e_req), 128'(1'b1));
    gnt = 1'b1;
    tick();
    cancel = 1'b1;
    tick();
    chk_eq("replay_req", 128'(e_req), 128'(1'b1));
    gnt = 1'b1;
    tick();
    tick();
    chk_eq("dealloc_win", 128'(e_dealloc), 128'(1'b1));
    tick();
    tick();

    // wakeup in the allocation cycle bypasses
    mk_q(7'h20, 1'b1, 6'd5, 1'b1, 6'd6);
    wake(0, 6'd5);
    wake(1, 6'd6);
    tick();
    chk_eq("bypass_req", 128'(e_req), 128'(1'b1));
    flush = 1'b1;
    frob  = 7'h20;
    tick();

    // flush racing a grant: younger entry dies, older one survives
    mk_q(7'h12, 1'b0, 6'd1, 1'b0, 6'd2);
    tick();
    flush = 1'b1;
    frob  = 7'h10;
    gnt   = 1'b1;
    tick();
    chk_eq("flush_kill", 128'(e_valid), 128'(1'b0));
    mk_q(7'h0F, 1'b0, 6'd1, 1'b0, 6'd2);
    tick();
    flush = 1'b1;
    frob  = 7'h10;
    gnt   = 1'b1;
    tick();
    chk_eq("flush_keep", 128'(e_valid), 128'(1'b1));
    flush = 1'b1;
    frob  = 7'h0F;
    tick();

    // wrap-bit compare
    mk_q({1'b1, 6'h02}, 1'b0, 6'd1, 1'b0, 6'd2);
    tick();
    flush = 1'b1;
    frob  = {1'b0, 6'h3E};
    tick();
    chk_eq("wrap_kill", 128'(e_valid), 128'(1'b0));

    // age saturation
    mk_q(7'h30, 1'b1, 6'd7, 1'b0, 6'd2);
    tick();
    repeat (20) tick();
    chk_eq("age_sat", 128'(e_age), 128'(15));
    flush = 1'b1;
    frob  = 7'h30;
    tick();

    // asynchronous reset while ISSUED, then a clean reallocation
    mk_q(7'h40, 1'b0, 6'd1, 1'b0, 6'd2);
    tick();
    gnt = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    chk_eq("rst_valid",   128'(e_valid),   128'(1'b0));
    chk_eq("rst_req",     128'(e_req),     128'(1'b0));
    chk_eq("rst_dealloc", 128'(e_dealloc), 128'(1'b0));
    chk_eq("rst_age",     128'(e_age),     128'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    mk_q(7'h41, 1'b0, 6'd3, 1'b0, 6'd4);
    tick();
    chk_eq("rst_realloc_req", 128'(e_req), 128'(1'b1));
    flush = 1'b1;
    frob  = 7'h41;
    tick();

    // random traffic
    repeat (600) begin
      if (!m_occ && $urandom_range(0, 2) == 0) begin
        mk_q(7'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
             1'($urandom), 6'($urandom_range(0, 7)));
        for (int s = 0; s < MAX_SRCS; s++)
          q.src[s].descr = ($urandom_range(0, 3) == 0) ? OPT_NONE : OPT_REG;
      end
      for (int i = 0; i < IPRF_NUM_WRITES; i++)
        if ($urandom_range(0, 3) == 0) wake(i, 6'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        frob  = 7'($urandom);
      end
      cancel = ($urandom_range(0, 3) == 0);
      gnt    = model_req() && ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
